// File: rtl/rr_priority_arbiter.sv
// Registered round-robin arbiter with priority levels.
// The highest requesting priority level wins. Within that level, a per-level pointer
// picks the first requester at or above it, wrapping around. An offer is held until
// it is accepted or the requester withdraws. Pointers move only on accept, so this
// can serve as the grant/accept stage of a p-iSLIP scheduler.
module rr_priority_arbiter #(
    parameter int N      = 25,
    parameter int PRIO_W = 2,
    parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          in_request,
    input  logic [N*PRIO_W-1:0]   in_prio,
    input  logic                  in_accept,
    output logic [N-1:0]          out_grant,
    output logic                  out_grant_valid,
    output logic [IDX_W-1:0]      out_grant_idx,
    output logic [PRIO_W-1:0]     out_grant_prio
);

    localparam int LEVELS = 2 ** PRIO_W;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    ptr [LEVELS];

    logic [PRIO_W-1:0]   top_lvl;
    logic [N-1:0]        lvl_req;
    logic [IDX_W-1:0]    sel_ptr;
    logic                hi_found;
    logic [IDX_W-1:0]    hi_idx;
    logic [IDX_W-1:0]    lo_idx;
    logic [IDX_W-1:0]    win_idx;
    logic [N-1:0]        win_onehot;
    logic                offer_withdrawn;

    // Pick the winning level and, within it, the first requester at or after ptr[level].
    always_comb begin
        top_lvl    = '0;
        lvl_req    = '0;
        hi_found   = 1'b0;
        hi_idx     = '0;
        lo_idx     = '0;
        win_onehot = '0;

        for (int i = 0; i < N; i++) begin
            if (in_request[i] && (in_prio[i*PRIO_W +: PRIO_W] > top_lvl)) begin
                top_lvl = in_prio[i*PRIO_W +: PRIO_W];
            end
        end

        for (int i = 0; i < N; i++) begin
            lvl_req[i] = in_request[i] && (in_prio[i*PRIO_W +: PRIO_W] == top_lvl);
        end

        sel_ptr = ptr[top_lvl];

        // Scan downward so the last hit in each half is its lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (lvl_req[i]) begin
                if (IDX_W'(i) >= sel_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end else begin
                    lo_idx   = IDX_W'(i);
                end
            end
        end

        win_idx = hi_found ? hi_idx : lo_idx;

        for (int i = 0; i < N; i++) begin
            win_onehot[i] = (IDX_W'(i) == win_idx);
        end

        offer_withdrawn = ~|(in_request & out_grant);
    end

    // Offer/accept state machine with registered outputs and per-level pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            out_grant       <= '0;
            out_grant_valid <= 1'b0;
            out_grant_idx   <= '0;
            out_grant_prio  <= '0;
            for (int l = 0; l < LEVELS; l++) begin
                ptr[l] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (|in_request) begin
                        out_grant       <= win_onehot;
                        out_grant_valid <= 1'b1;
                        out_grant_idx   <= win_idx;
                        out_grant_prio  <= top_lvl;
                        state           <= OFFER;
                    end
                end
                OFFER: begin
                    if (in_accept || offer_withdrawn) begin
                        // Accept takes precedence over a simultaneous withdraw.
                        if (in_accept) begin
                            ptr[out_grant_prio] <= (out_grant_idx == IDX_W'(N - 1))
                                                   ? '0 : out_grant_idx + IDX_W'(1);
                        end
                        out_grant       <= '0;
                        out_grant_valid <= 1'b0;
                        out_grant_idx   <= '0;
                        out_grant_prio  <= '0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: an N=4 instance driven by directed steps and random
// traffic, plus a default N=25 instance driven by random traffic. Both are compared
// every cycle against a queue-free behavioural model using modulo index arithmetic.
module tb_rr_priority_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  req4;
    logic [7:0]  prio4;
    logic        acc4;
    logic [3:0]  grant4;
    logic        valid4;
    logic [1:0]  idx4;
    logic [1:0]  gprio4;

    logic [24:0] req25;
    logic [49:0] prio25;
    logic        acc25;
    logic [24:0] grant25;
    logic        valid25;
    logic [4:0]  idx25;
    logic [1:0]  gprio25;

    int checks = 0;
    int errors = 0;

    // Model state per instance (0: N=4, 1: N=25)
    int m_ptr   [2][4];
    bit m_valid [2];
    int m_idx   [2];
    int m_prio  [2];

    always #5 clk = ~clk;

    rr_priority_arbiter #(.N(4), .PRIO_W(2)) dut4 (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_request      (req4),
        .in_prio         (prio4),
        .in_accept       (acc4),
        .out_grant       (grant4),
        .out_grant_valid (valid4),
        .out_grant_idx   (idx4),
        .out_grant_prio  (gprio4)
    );

    rr_priority_arbiter dut25 (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_request      (req25),
        .in_prio         (prio25),
        .in_accept       (acc25),
        .out_grant       (grant25),
        .out_grant_valid (valid25),
        .out_grant_idx   (idx25),
        .out_grant_prio  (gprio25)
    );

    function automatic void model_step(int u, int n, logic [24:0] req, logic [49:0] pr,
                                       bit acc, bit rstn);
        int best;
        if (!rstn) begin
            m_valid[u] = 0;
            m_idx[u]   = 0;
            m_prio[u]  = 0;
            for (int l = 0; l < 4; l++) m_ptr[u][l] = 0;
        end else if (!m_valid[u]) begin
            best = -1;
            for (int i = 0; i < n; i++)
                if (req[i] && int'(pr[2*i +: 2]) > best) best = int'(pr[2*i +: 2]);
            if (best >= 0) begin
                for (int k = 0; k < n; k++) begin
                    int j;
                    j = (m_ptr[u][best] + k) % n;
                    if (req[j] && int'(pr[2*j +: 2]) == best) begin
                        m_idx[u] = j;
                        break;
                    end
                end
                m_prio[u]  = best;
                m_valid[u] = 1;
            end
        end else if (acc) begin
            m_ptr[u][m_prio[u]] = (m_idx[u] + 1) % n;
            m_valid[u] = 0;
            m_idx[u]   = 0;
            m_prio[u]  = 0;
        end else if (!req[m_idx[u]]) begin
            m_valid[u] = 0;
            m_idx[u]   = 0;
            m_prio[u]  = 0;
        end
    endfunction

    function automatic logic [24:0] exp_grant(int u);
        logic [24:0] one;
        one = 25'd1;
        return m_valid[u] ? (one << m_idx[u]) : 25'd0;
    endfunction

    task automatic check_all(input string tag);
        logic [24:0] g0, g1;
        g0 = exp_grant(0);
        g1 = exp_grant(1);
        checks++;
        assert (grant4 === g0[3:0]) else begin
            errors++; $error("FAIL %s grant4 observed=%b expected=%b", tag, grant4, g0[3:0]);
        end
        checks++;
        assert (valid4 === m_valid[0]) else begin
            errors++; $error("FAIL %s valid4 observed=%b expected=%b", tag, valid4, m_valid[0]);
        end
        checks++;
        assert (idx4 === 2'(m_idx[0])) else begin
            errors++; $error("FAIL %s idx4 observed=%0d expected=%0d", tag, idx4, m_idx[0]);
        end
        checks++;
        assert (gprio4 === 2'(m_prio[0])) else begin
            errors++; $error("FAIL %s prio4 observed=%0d expected=%0d", tag, gprio4, m_prio[0]);
        end
        checks++;
        assert (grant25 === g1) else begin
            errors++; $error("FAIL %s grant25 observed=%h expected=%h", tag, grant25, g1);
        end
        checks++;
        assert (valid25 === m_valid[1]) else begin
            errors++; $error("FAIL %s valid25 observed=%b expected=%b", tag, valid25, m_valid[1]);
        end
        checks++;
        assert (idx25 === 5'(m_idx[1])) else begin
            errors++; $error("FAIL %s idx25 observed=%0d expected=%0d", tag, idx25, m_idx[1]);
        end
        checks++;
        assert (gprio25 === 2'(m_prio[1])) else begin
            errors++; $error("FAIL %s prio25 observed=%0d expected=%0d", tag, gprio25, m_prio[1]);
        end
    endtask

    // One clock: inputs already set, model follows the edge, outputs checked on negedge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step(0, 4, {21'd0, req4}, {42'd0, prio4}, acc4, rst_n);
        model_step(1, 25, req25, prio25, acc25, rst_n);
        @(negedge clk);
        check_all(tag);
    endtask

    // Hand-derived expectation for the N=4 instance, independent of the model.
    task automatic expect4(input string tag, input logic v, input logic [1:0] i,
                           input logic [1:0] p);
        logic [3:0] g;
        g = v ? (4'b0001 << i) : 4'b0000;
        checks++;
        assert (valid4 === v && grant4 === g && idx4 === (v ? i : 2'd0)
                && gprio4 === (v ? p : 2'd0)) else begin
            errors++;
            $error("FAIL %s observed v=%b g=%b i=%0d p=%0d expected v=%b g=%b i=%0d p=%0d",
                   tag, valid4, grant4, idx4, gprio4, v, g, i, p);
        end
    endtask

    initial begin
        int seq [5];
        seq = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        req4 = '0; prio4 = '0; acc4 = 1'b0;
        req25 = '0; prio25 = '0; acc25 = 1'b0;
        @(negedge clk);

        // 1: reset, then idle with no requests
        cycle("rst");
        cycle("rst");
        expect4("rst_out", 1'b0, 2'd0, 2'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) cycle("idle");
        expect4("idle_out", 1'b0, 2'd0, 2'd0);

        // 2: all requesting at level 0, accept every offer
        req4 = 4'b1111; prio4 = 8'h00; acc4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle("rr_offer");
            expect4("rr_seq", 1'b1, 2'(seq[k]), 2'd0);
            cycle("rr_bubble");
            expect4("rr_bubble", 1'b0, 2'd0, 2'd0);
        end
        // ptr[0] is now 1
        req4 = 4'b0000; acc4 = 1'b0;
        cycle("gap");

        // 3: highest level wins; only its pointer moves
        req4 = 4'b0101; prio4 = 8'b0011_0001;
        cycle("prio_offer");
        expect4("prio_win", 1'b1, 2'd2, 2'd3);
        acc4 = 1'b1; req4 = 4'b0000;
        cycle("prio_acc");
        acc4 = 1'b0; req4 = 4'b0011; prio4 = 8'b0000_0101;
        cycle("lvl1_offer");
        expect4("lvl1_ptr_untouched", 1'b1, 2'd0, 2'd1);
        acc4 = 1'b1; req4 = 4'b0000;
        cycle("lvl1_acc");
        acc4 = 1'b0; req4 = 4'b1111; prio4 = 8'hFF;
        cycle("lvl3_offer");
        expect4("lvl3_ptr_is_3", 1'b1, 2'd3, 2'd3);
        acc4 = 1'b1; req4 = 4'b0000;
        cycle("lvl3_acc");
        acc4 = 1'b0;
        cycle("gap");

        // 4: offer idx 1 held without preemption, then withdrawn
        req4 = 4'b0010; prio4 = 8'h00;
        cycle("hold_offer");
        req4 = 4'b1010; prio4 = 8'b1100_0000;
        for (int k = 0; k < 4; k++) begin
            cycle("hold");
            expect4("hold_no_preempt", 1'b1, 2'd1, 2'd0);
        end
        req4 = 4'b1000;
        cycle("withdraw");
        expect4("withdraw_clear", 1'b0, 2'd0, 2'd0);
        req4 = 4'b0000;
        cycle("gap");

        // 5: accept and withdraw together, accept wins (ptr[0] 1 -> 3)
        req4 = 4'b0100; prio4 = 8'h00;
        cycle("aw_offer");
        expect4("aw_offer", 1'b1, 2'd2, 2'd0);
        acc4 = 1'b1; req4 = 4'b0000;
        cycle("aw_same");
        expect4("aw_clear", 1'b0, 2'd0, 2'd0);
        acc4 = 1'b0; req4 = 4'b1111;
        cycle("aw_next");
        expect4("aw_ptr_is_3", 1'b1, 2'd3, 2'd0);

        // 6: reset during a pending offer
        rst_n = 1'b0;
        cycle("mid_rst");
        expect4("mid_rst_clear", 1'b0, 2'd0, 2'd0);
        rst_n = 1'b1; req4 = 4'b0110; prio4 = 8'b0001_0100;
        cycle("post_rst");
        expect4("post_rst_first", 1'b1, 2'd1, 2'd1);

        // Random traffic on both instances
        for (int k = 0; k < 600; k++) begin
            rst_n  = ($urandom_range(0, 99) != 0);
            req4   = 4'($urandom);
            prio4  = 8'($urandom);
            acc4   = ($urandom_range(0, 2) == 0);
            req25  = 25'($urandom) & 25'($urandom | $urandom);
            prio25 = {18'($urandom), 32'($urandom)};
            acc25  = ($urandom_range(0, 2) == 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
